// File: rtl/alu_types_pkg.sv
// Shared ALU type definitions: the operation encoding used by the ALU and every client of it.
package alu_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_control_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU with signed-overflow, zero-result and operand-equality flags.
module alu
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t op,
  output logic [N-1:0] out,
  output logic         overflow,
  output logic         outputs_zero,
  output logic         inputs_equal
);

  localparam int SHW = $clog2(N);

  logic signed [N-1:0] sa, sb;
  logic signed [N:0]   sum_x, dif_x;
  logic [SHW-1:0]      shamt;

  assign sa    = a;
  assign sb    = b;
  assign shamt = b[SHW-1:0];
  // One extra bit of sign extension: the top two bits disagree exactly on signed overflow.
  assign sum_x = {sa[N-1], sa} + {sb[N-1], sb};
  assign dif_x = {sa[N-1], sa} - {sb[N-1], sb};

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        out      = sum_x[N-1:0];
        overflow = sum_x[N] ^ sum_x[N-1];
      end
      ALU_SUB: begin
        out      = dif_x[N-1:0];
        overflow = dif_x[N] ^ dif_x[N-1];
      end
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_XOR:  out = a ^ b;
      ALU_SLL:  out = a << shamt;
      ALU_SRL:  out = a >> shamt;
      ALU_SRA:  out = $unsigned(sa >>> shamt);
      ALU_SLT:  out = {{(N-1){1'b0}}, (sa < sb)};
      ALU_SLTU: out = {{(N-1){1'b0}}, (a < b)};
      default:  out = '0;
    endcase
  end

  assign outputs_zero = (out == '0);
  assign inputs_equal = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE -> EXEC -> RESP, one command in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise req0 has fixed priority.
module alu_arbiter
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  alu_control_t req0_op,
  input  alu_control_t req1_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_equal,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  alu_control_t op_q;
  logic [N-1:0] a_q, b_q;
  logic         id_q;
  logic         idle, grant, accept;
  logic [N-1:0] alu_out;
  logic         alu_ovf, alu_zero, alu_eq;

  assign idle = (state_q == S_IDLE);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = ~req0_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant;
  end
`else
  assign grant = ~req0_valid;
`endif

  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_EXEC;
      S_EXEC:                 state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Command capture: IDLE -> EXEC
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= grant ? req1_op : req0_op;
      a_q  <= grant ? req1_a  : req0_a;
      b_q  <= grant ? req1_b  : req0_b;
      id_q <= grant;
    end
  end

  alu #(.N(N)) u_alu (
    .a            (a_q),
    .b            (b_q),
    .op           (op_q),
    .out          (alu_out),
    .overflow     (alu_ovf),
    .outputs_zero (alu_zero),
    .inputs_equal (alu_eq)
  );

  // Result register: EXEC -> RESP; loaded only in EXEC so it stays stable through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_equal    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_id       <= id_q;
      rsp_result   <= alu_out;
      rsp_overflow <= alu_ovf;
      rsp_zero     <= alu_zero;
      rsp_equal    <= alu_eq;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized self-checking bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_types::*;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  alu_control_t req0_op, req1_op;
  logic [31:0]  req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_equal, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        ov;
    logic        z;
    logic        eq;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  alu_arbiter #(.N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_op      (req0_op),
    .req1_op      (req1_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_equal    (rsp_equal),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input alu_control_t op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ov = 1'b0;
    case (op)
      ALU_ADD: begin
        e.r  = a + b;
        e.ov = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      ALU_SUB: begin
        e.r  = a - b;
        e.ov = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      ALU_AND:  e.r = a & b;
      ALU_OR:   e.r = a | b;
      ALU_XOR:  e.r = a ^ b;
      ALU_SLL:  e.r = a << b[4:0];
      ALU_SRL:  e.r = a >> b[4:0];
      ALU_SRA:  e.r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.r = (a < b) ? 32'd1 : 32'd0;
      default:  e.r = 32'd0;
    endcase
    e.z  = (e.r == 32'd0);
    e.eq = (a == b);
    return e;
  endfunction

  // Waits (bounded) for a ready at a falling edge; reports which requester was accepted.
  task automatic wait_ready(output logic who, output logic ok);
    ok  = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        who = req1_ready;
        ok  = 1'b1;
        return;
      end
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        return;
      end
    end
    check("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Presents one command, waits for acceptance, then withdraws it just after the accepting edge.
  task automatic send(input logic id, input alu_control_t op, input logic [31:0] a, input logic [31:0] b);
    logic who, ok;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    wait_ready(who, ok);
    if (ok) check("send_grant", {31'd0, who}, {31'd0, id});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    logic        who, ok, done, prev_ok;
    int          prev_cyc;
    exp_t        e;
    alu_control_t rop;
    logic [31:0] ra, rb;

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = ALU_ADD; req1_op = ALU_ADD;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy",   {31'd0, busy},         32'd0);
    check("rst_valid",  {31'd0, rsp_valid},    32'd0);
    check("rst_id",     {31'd0, rsp_id},       32'd0);
    check("rst_result", rsp_result,            32'd0);
    check("rst_flags",  {29'd0, rsp_overflow, rsp_zero, rsp_equal}, 32'd0);

    // ADD overflow from req0, response two cycles after the accept.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
    @(negedge clk);
    check("add_r0_ready", {31'd0, req0_ready}, 32'd1);
    check("add_r1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("add_exec_busy",  {31'd0, busy},      32'd1);
    check("add_exec_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("add_valid",  {31'd0, rsp_valid},    32'd1);
    check("add_result", rsp_result,            32'h8000_0000);
    check("add_ovf",    {31'd0, rsp_overflow}, 32'd1);
    check("add_zero",   {31'd0, rsp_zero},     32'd0);
    check("add_equal",  {31'd0, rsp_equal},    32'd0);
    check("add_id",     {31'd0, rsp_id},       32'd0);
    @(negedge clk);
    check("add_back_idle", {31'd0, busy}, 32'd0);

    // SUB from req1 with rsp_ready held low; a stray req0 must not be accepted meanwhile.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd5; req1_b = 32'd5;
    @(negedge clk);
    check("sub_r1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_OR; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    check("sub_exec_r0_ready", {31'd0, req0_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sub_hold_valid",    {31'd0, rsp_valid},  32'd1);
      check("sub_hold_result",   rsp_result,          32'd0);
      check("sub_hold_zero",     {31'd0, rsp_zero},   32'd1);
      check("sub_hold_equal",    {31'd0, rsp_equal},  32'd1);
      check("sub_hold_id",       {31'd0, rsp_id},     32'd1);
      check("sub_hold_r0_ready", {31'd0, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("sub_last_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("sub_back_idle", {31'd0, busy}, 32'd0);

    // Shift amount taken from b[4:0] only.
    send(1'b0, ALU_SLL, 32'd1, 32'h0000_0024);
    wait_rsp(ok);
    if (ok) begin
      check("sll_result", rsp_result,      32'h0000_0010);
      check("sll_id",     {31'd0, rsp_id}, 32'd0);
    end

    // Both requesters valid continuously: grant sequence and 3-cycle spacing.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'd10; req1_b = 32'd20;
    prev_cyc = 0;
    prev_ok  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(who, ok);
      if (ok) begin
        check("both_grant", {31'd0, who}, RR ? k % 2 : 32'd0);
        if (prev_ok) check("both_spacing", cyc - prev_cyc, 32'd3);
        prev_cyc = cyc;
      end
      prev_ok = ok;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while in EXEC drops the command.
    send(1'b0, ALU_ADD, 32'd3, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstx_busy",   {31'd0, busy},      32'd0);
    check("rstx_valid",  {31'd0, rsp_valid}, 32'd0);
    check("rstx_result", rsp_result,         32'd0);
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) done = 1'b1;
    end
    check("rstx_no_rsp", {31'd0, done}, 32'd0);

    // Randomized commands against the behavioural model.
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      req0_valid = $urandom_range(0, 1);
      req1_valid = !req0_valid || ($urandom_range(0, 1) == 1);
      req0_op = alu_control_t'($urandom_range(0, 9));
      req1_op = alu_control_t'($urandom_range(0, 9));
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      rsp_ready = $urandom_range(0, 1);
      wait_ready(who, ok);
      if (!ok) break;
      rop = who ? req1_op : req0_op;
      ra  = who ? req1_a  : req0_a;
      rb  = who ? req1_b  : req0_b;
      if (who) q1.push_back(model(rop, ra, rb));
      else     q0.push_back(model(rop, ra, rb));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
          done = 1'b1;
          if (rsp_id ? (q1.size() == 0) : (q0.size() == 0)) begin
            check("rnd_unexpected_rsp", {31'd0, rsp_id}, 32'd2);
          end else begin
            e = rsp_id ? q1.pop_front() : q0.pop_front();
            check("rnd_id",     {31'd0, rsp_id},       {31'd0, who});
            check("rnd_result", rsp_result,            e.r);
            check("rnd_flags",  {29'd0, rsp_overflow, rsp_zero, rsp_equal}, {29'd0, e.ov, e.z, e.eq});
          end
        end else begin
          @(posedge clk); #1 rsp_ready = $urandom_range(0, 1);
        end
      end
      if (!done) check("rnd_rsp_timeout", 32'd0, 32'd1);
    end
    check("rnd_q0_drained", q0.size(), 32'd0);
    check("rnd_q1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning the operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, meaning requester i presents a command.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, meaning the command is accepted this cycle.
REQ-006 SHALL have ports req0_op and req1_op, input, alu_control_t, meaning the requested ALU operation.
REQ-007 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, N each, meaning the operands.
REQ-008 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), meaning the response handshake.
REQ-009 SHALL have port rsp_id, output, 1, meaning the index of the requester that owns the response.
REQ-010 SHALL have port rsp_result, output, N, meaning the ALU result.
REQ-011 SHALL have ports rsp_overflow, rsp_zero and rsp_equal, output, 1 each, meaning the ALU flags.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, EXEC and RESP.
REQ-014 In IDLE, SHALL drive reqi_ready=1 combinationally for exactly the granted requester, and only when that requester's valid is high.
REQ-015 On a transfer (valid&&ready) in IDLE, SHALL capture op, a, b and the requester id into registers and go to EXEC.
REQ-016 In EXEC, SHALL drive the shared ALU from the captured registers, register out, overflow, outputs_zero and inputs_equal into rsp_*, and go to RESP.
REQ-017 In RESP, SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to IDLE.
REQ-018 rsp_valid SHALL therefore rise 2 cycles after the accepting edge; minimum spacing between accepts SHALL be 3 cycles.
REQ-019 SHALL hold both reqi_ready low in EXEC and RESP, and ignore any valid in those states.
REQ-020 SHALL pass operands to the ALU unmodified; shift ops SHALL use b[4:0] as decided inside the ALU, with no masking in the arbiter.
REQ-021 If rsp_ready is high on the first RESP cycle, SHALL complete the response in that cycle and be back in IDLE the following cycle.
REQ-022 With no valid request in IDLE, SHALL remain in IDLE and leave the grant state unchanged.

Reset
REQ-023 On rst, SHALL set state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, all rsp flags=0, and last_grant=1.
REQ-024 rst during EXEC or RESP SHALL drop the transaction with no response issued.

Configuration
REQ-025 With ALU_ARB_ROUND_ROBIN_EN defined, when both requests are valid SHALL grant the requester not equal to last_grant, and update last_grant on each transfer.
REQ-026 Without ALU_ARB_ROUND_ROBIN_EN, SHALL use fixed priority with req0 always winning; the last_grant register is absent or unused.

Structure
REQ-027 alu_control_t and its op encodings SHALL come from the shared alu_types package; no new typedefs are introduced there.
REQ-028 The FSM state enum SHALL be local to alu_arbiter.
REQ-029 SHALL instantiate exactly one sub-module, alu, with ports a, b, op, out, overflow, outputs_zero and inputs_equal.

Verification
REQ-030 After reset, req0: ALU_ADD, a=0x7FFFFFFF, b=1 -> req0_ready=1 for 1 cycle; rsp_valid 2 cycles later with result=0x80000000, overflow=1, zero=0, equal=0, rsp_id=0.
REQ-031 req1: ALU_SUB, a=b=0x00000005, with rsp_ready held low 4 cycles -> rsp_valid held, result=0, zero=1, equal=1; no ready during the hold.
REQ-032 Both valid continuously with rsp_ready=1 (round-robin) -> grants 0,1,0,1 at a 3-cycle spacing; without the macro -> 0,0,0,0.
REQ-033 req0: ALU_SLL, a=1, b=0x00000024 -> result=0x00000010, since only b[4:0]=4 is used.
REQ-034 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, and no response for the dropped command.
REQ-035 Scoreboard: 200 random commands from both requesters with random rsp_ready -> every response matches the behavioural ALU model, and the per-requester order is preserved.
